// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet framing stage.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } pkt_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int PKT_MAX_LEN = 16;

    // Index/length width: must hold 0..max_len inclusive.
    function automatic int idx_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int PKT_IDX_W = idx_width(PKT_MAX_LEN);

endpackage

// File: rtl/uart_pkt_rx_if.sv
// Payload byte stream leaving the framer; master drives data, slave drives i_ready.
interface uart_pkt_rx_if #(
    parameter int LEN_W = uart_pkg::PKT_IDX_W
);
    logic [7:0]       o_data;
    logic             o_valid;
    logic             i_ready;
    logic             o_last;
    logic [LEN_W-1:0] o_pkt_len;

    modport master (output o_data, o_valid, o_last, o_pkt_len, input i_ready);
    modport slave  (input o_data, o_valid, o_last, o_pkt_len, output i_ready);
endinterface

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 registers, one write port.
// Latency: write lands on the next edge; read port is combinational.
// Backpressure: none, the framer owns all sequencing.
module uart_pkt_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_pkt_rx.sv
// Frame parser: SOF, LEN, payload, additive checksum; releases good payloads.
// Latency: o_valid rises the cycle after the CHK byte, then 1 byte/clk.
// Backpressure: o_data/o_last/o_pkt_len hold while o_valid & !i_ready; bytes in DRAIN are dropped.
module uart_pkt_rx
    import uart_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF           = SOF_DEFAULT,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    input  logic         i_tick,
    uart_pkt_rx_if.master stream,
    output logic         o_err_chk,
    output logic         o_err_len,
    output logic         o_err_tout,
    output logic         o_err_ovr,
    output logic         o_busy
);
    localparam int IDX_W  = idx_width(MAX_LEN);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TOUT_W = $clog2(TIMEOUT_TICKS);

    pkt_state_t        state;
    logic [IDX_W-1:0]  pkt_len_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rd_next;
    logic [7:0]        sum_q;
    logic [TOUT_W-1:0] tout_cnt;
    logic [BUF_AW-1:0] rd_addr;
    logic [7:0]        rd_dat;
    logic              buf_we;
    logic              handshake;
    logic              len_ok;
    logic              timed;
    logic              tout_hit;

    assign handshake = stream.o_valid & stream.i_ready;
    assign rd_next   = rd_idx + IDX_W'(1);
    // The CHK cycle preloads entry 0; during DRAIN we prefetch the next entry.
    assign rd_addr   = (state == CHK) ? '0 : rd_next[BUF_AW-1:0];
    assign buf_we    = (state == PAYLOAD) && i_rx_valid;
    assign len_ok    = (i_rx_data != 8'd0) && (i_rx_data <= 8'(MAX_LEN));
    assign timed     = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign tout_hit  = i_tick && (tout_cnt == TOUT_W'(TIMEOUT_TICKS - 1));
    assign o_busy    = (state != HUNT);

    uart_pkt_buf #(.MAX_LEN(MAX_LEN), .AW(BUF_AW)) u_buf (
        .i_clk (i_clk),
        .we    (buf_we),
        .waddr (wr_idx[BUF_AW-1:0]),
        .wdata (i_rx_data),
        .raddr (rd_addr),
        .rdata (rd_dat)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= HUNT;
            pkt_len_q        <= '0;
            wr_idx           <= '0;
            rd_idx           <= '0;
            sum_q            <= '0;
            tout_cnt         <= '0;
            stream.o_data    <= '0;
            stream.o_valid   <= 1'b0;
            stream.o_last    <= 1'b0;
            stream.o_pkt_len <= '0;
            o_err_chk        <= 1'b0;
            o_err_len        <= 1'b0;
            o_err_tout       <= 1'b0;
            o_err_ovr        <= 1'b0;
        end else begin
            o_err_chk  <= 1'b0;
            o_err_len  <= 1'b0;
            o_err_tout <= 1'b0;
            o_err_ovr  <= 1'b0;

            case (state)
                HUNT: begin
                    if (i_rx_valid && (i_rx_data == SOF)) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (i_rx_valid) begin
                        if (len_ok) begin
                            pkt_len_q <= i_rx_data[IDX_W-1:0];
                            sum_q     <= i_rx_data;
                            wr_idx    <= '0;
                            state     <= PAYLOAD;
                        end else begin
                            o_err_len <= 1'b1;
                            state     <= HUNT;
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_rx_valid) begin
                        sum_q  <= sum_q + i_rx_data;
                        wr_idx <= wr_idx + IDX_W'(1);
                        if ((wr_idx + IDX_W'(1)) == pkt_len_q) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (i_rx_valid) begin
                        if ((sum_q + i_rx_data) == 8'd0) begin
                            rd_idx           <= '0;
                            stream.o_data    <= rd_dat;
                            stream.o_valid   <= 1'b1;
                            stream.o_last    <= (pkt_len_q == IDX_W'(1));
                            stream.o_pkt_len <= pkt_len_q;
                            state            <= DRAIN;
                        end else begin
                            o_err_chk <= 1'b1;
                            state     <= HUNT;
                        end
                    end
                end
                DRAIN: begin
                    if (i_rx_valid) begin
                        o_err_ovr <= 1'b1;
                    end
                    if (handshake) begin
                        if (stream.o_last) begin
                            stream.o_valid <= 1'b0;
                            stream.o_last  <= 1'b0;
                            state          <= HUNT;
                        end else begin
                            rd_idx        <= rd_next;
                            stream.o_data <= rd_dat;
                            stream.o_last <= (rd_next == (pkt_len_q - IDX_W'(1)));
                        end
                    end
                end
                default: state <= HUNT;
            endcase

            // Inter-byte watchdog; a byte in the expiring cycle takes priority.
            if (!timed || i_rx_valid) begin
                tout_cnt <= '0;
            end else if (tout_hit) begin
                tout_cnt   <= '0;
                o_err_tout <= 1'b1;
                state      <= HUNT;
            end else if (i_tick) begin
                tout_cnt <= tout_cnt + TOUT_W'(1);
            end
        end
    end
endmodule
